// File: rtl/instr_enc_pkg.sv
// Shared opcode/funct constants, instruction format and loader state types
// for the instruction encoder.
package instr_enc_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FT_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned WORD_W = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OP_COP0  = 6'b010000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FT_W-1:0] FT_ADD  = 6'b100000;
  localparam logic [FT_W-1:0] FT_ADDU = 6'b100001;
  localparam logic [FT_W-1:0] FT_SUB  = 6'b100010;
  localparam logic [FT_W-1:0] FT_AND  = 6'b100100;
  localparam logic [FT_W-1:0] FT_OR   = 6'b100101;
  localparam logic [FT_W-1:0] FT_NOR  = 6'b100111;
  localparam logic [FT_W-1:0] FT_SLT  = 6'b101010;
  localparam logic [FT_W-1:0] FT_SLTU = 6'b101011;
  localparam logic [FT_W-1:0] FT_SLL  = 6'b000000;
  localparam logic [FT_W-1:0] FT_SRL  = 6'b000010;
  localparam logic [FT_W-1:0] FT_SRA  = 6'b000011;
  localparam logic [FT_W-1:0] FT_JR   = 6'b001000;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FULL
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI, OP_COP0, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ft_legal(input logic [FT_W-1:0] ft);
    case (ft)
      FT_ADD, FT_ADDU, FT_SUB, FT_AND, FT_OR, FT_NOR, FT_SLT, FT_SLTU,
      FT_SLL, FT_SRL, FT_SRA, FT_JR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fmt_pack.sv
// Combinational packer: selects R/I/J format from the opcode, builds the
// 32-bit instruction word and flags whether the opcode/funct pair is legal.
module instr_fmt_pack
  import instr_enc_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [FT_W-1:0]   ft,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic [SH_W-1:0]   shamt,
  input  logic [IMM_W-1:0]  imm,
  input  logic [TGT_W-1:0]  target,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  fmt_e fmt;

  always_comb begin
    fmt = FMT_I;
    if (op == OP_RTYPE) begin
      fmt = FMT_R;
    end else if (op == OP_J || op == OP_JAL) begin
      fmt = FMT_J;
    end
  end

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {op, rs, rt, rd, shamt, ft};
      FMT_J:   word = {op, target};
      default: word = {op, rs, rt, imm};
    endcase
  end

  // funct only matters for R-format words
  always_comb begin
    legal = op_legal(op) && ((fmt != FMT_R) || ft_legal(ft));
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: handshake, S1 write stage, write pointer and fill FSM.
// Optional: define INSTR_ENC_LEGAL_CHECK_EN to drop illegal bundles and pulse err.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [FT_W-1:0]   in_ft,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [SH_W-1:0]   in_shamt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [TGT_W-1:0]  in_target,
  input  logic              addr_clr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(2**ADDR_W);

  logic [WORD_W-1:0] word;
  logic              legal;
  logic              accept;
  logic              commit;
  logic [ADDR_W:0]   wp;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [WORD_W-1:0] s1_data;
  logic              err_q;
  state_e            state, state_nxt;

  instr_fmt_pack u_pack (
    .op     (in_op),
    .ft     (in_ft),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (word),
    .legal  (legal)
  );

  assign in_ready = !rst && !full && !addr_clr;
  assign accept   = in_valid && in_ready;

`ifdef INSTR_ENC_LEGAL_CHECK_EN
  assign commit = accept && legal;
`else
  logic unused_legal;
  assign unused_legal = legal;
  assign commit       = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
    end else if (addr_clr) begin
      wp <= '0;
    end else if (commit) begin
      wp <= wp + 1'b1;
    end
  end

  // S1 write stage; async reset squashes an in-flight write at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_data  <= '0;
      err_q    <= 1'b0;
    end else begin
      s1_valid <= commit;
`ifdef INSTR_ENC_LEGAL_CHECK_EN
      err_q    <= accept && !legal;
`else
      err_q    <= 1'b0;
`endif
      if (commit) begin
        s1_addr <= wp[ADDR_W-1:0];
        s1_data <= word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (addr_clr) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (commit) state_nxt = (wp + 1'b1 == CNT_MAX) ? ST_FULL : ST_LOAD;
        ST_LOAD: if (commit && (wp + 1'b1 == CNT_MAX)) state_nxt = ST_FULL;
        ST_FULL: state_nxt = ST_FULL;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    full = (state == ST_FULL);
  end

  assign mem_we    = s1_valid;
  assign mem_addr  = s1_addr;
  assign mem_wdata = s1_data;
  assign count     = wp;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (ADDR_W=2); follows INSTR_ENC_LEGAL_CHECK_EN
// for the illegal-opcode expectations.
module tb_instr_encoder;
  import instr_enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [5:0]  in_ft;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        addr_clr;
  logic        mem_we;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  count;
  logic        full;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ft     (in_ft),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .addr_clr  (addr_clr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  // Presents one bundle for one cycle; called 1 time unit after a rising edge.
  task automatic send(input logic [5:0] op, input logic [5:0] ft, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [25:0] tgt);
    in_op = op; in_ft = ft; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic clear();
    addr_clr = 1'b1;
    @(posedge clk); #1;
    addr_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; addr_clr = 1'b0;
    in_op = '0; in_ft = '0; in_rs = '0; in_rt = '0; in_rd = '0;
    in_shamt = '0; in_imm = '0; in_target = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0d want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (full !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_full_err got %b%b want 00", full, err); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got %b want 1", in_ready); end
  endtask

  task automatic test_r_type();
    send(6'b000000, 6'b100000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL add_we got %b want 1", mem_we); end
    n_checks++; if (mem_addr !== 2'd0) begin n_fail++; $display("FAIL add_addr got %0d want 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h00221820) begin n_fail++; $display("FAIL add_wdata got %h want 00221820", mem_wdata); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL add_count got %0d want 1", count); end
    n_checks++; if (dut.state !== ST_LOAD) begin n_fail++; $display("FAIL add_state got %0d want LOAD", dut.state); end
    @(posedge clk); #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL add_we_drop got %b want 0", mem_we); end
  endtask

  task automatic test_back_to_back();
    clear();
    send(6'b100011, 6'b0, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h8FA80004) begin
      n_fail++; $display("FAIL b2b_lw got we=%b addr=%0d data=%h want 1/0/8fa80004", mem_we, mem_addr, mem_wdata);
    end
    send(6'b000100, 6'b0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'h1022FFFF) begin
      n_fail++; $display("FAIL b2b_beq got we=%b addr=%0d data=%h want 1/1/1022ffff", mem_we, mem_addr, mem_wdata);
    end
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got %0d want 2", count); end
  endtask

  task automatic test_j_type();
    clear();
    send(6'b000011, 6'b111111, 5'd31, 5'd17, 5'd9, 5'd4, 16'hABCD, 26'h0100000);
    n_checks++; if (mem_wdata !== 32'h0C100000 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL jal got we=%b data=%h want 1/0c100000", mem_we, mem_wdata);
    end
  endtask

  task automatic test_full();
    clear();
    for (int i = 0; i < 4; i++) begin
      send(6'b001000, 6'b0, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'h0);
    end
    n_checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      n_fail++; $display("FAIL full_set got full=%b ready=%b count=%0d want 1/0/4", full, in_ready, count);
    end
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd3 || mem_wdata !== 32'h20010003) begin
      n_fail++; $display("FAIL full_last_write got we=%b addr=%0d data=%h want 1/3/20010003", mem_we, mem_addr, mem_wdata);
    end
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem_we !== 1'b0 || count !== 3'd4 || dut.state !== ST_FULL) begin
      n_fail++; $display("FAIL full_stall got we=%b count=%0d state=%0d want 0/4/FULL", mem_we, count, dut.state);
    end
    addr_clr = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ready got %b want 0", in_ready); end
    @(posedge clk); #1;
    addr_clr = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (count !== 3'd0 || full !== 1'b0 || dut.state !== ST_IDLE || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL clr_state got count=%0d full=%b state=%0d we=%b want 0/0/IDLE/0", count, full, dut.state, mem_we);
    end
    send(6'b000000, 6'b100101, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'h00853025 || count !== 3'd1) begin
      n_fail++; $display("FAIL clr_rewrite got we=%b addr=%0d data=%h count=%0d want 1/0/00853025/1", mem_we, mem_addr, mem_wdata, count);
    end
  endtask

  task automatic test_clr_inflight();
    clear();
    send(6'b101011, 6'b0, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0);
    // word in S1 while clear and a new beat arrive together
    addr_clr = 1'b1;
    in_op = 6'b001101; in_valid = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b1 || mem_addr !== 2'd0 || mem_wdata !== 32'hAC430010) begin
      n_fail++; $display("FAIL clr_inflight got we=%b addr=%0d data=%h want 1/0/ac430010", mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    addr_clr = 1'b0; in_valid = 1'b0;
    n_checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL clr_beat_dropped got we=%b count=%0d want 0/0", mem_we, count);
    end
  endtask

  task automatic test_illegal();
    clear();
    send(6'b111111, 6'b0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
`ifdef INSTR_ENC_LEGAL_CHECK_EN
    n_checks++; if (err !== 1'b1 || mem_we !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL illegal_drop got err=%b we=%b count=%0d want 1/0/0", err, mem_we, count);
    end
    @(posedge clk); #1;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse got %b want 0", err); end
`else
    n_checks++; if (err !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'hFC000000 || count !== 3'd1) begin
      n_fail++; $display("FAIL illegal_write got err=%b we=%b data=%h count=%0d want 0/1/fc000000/1", err, mem_we, mem_wdata, count);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    clear();
    send(6'b001000, 6'b0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'h0);
    n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL pre_rst_we got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    n_checks++; if (mem_we !== 1'b0 || count !== 3'd0) begin
      n_fail++; $display("FAIL rst_squash got we=%b count=%0d want 0/0", mem_we, count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (count !== 3'd0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
      n_fail++; $display("FAIL post_rst got count=%0d ready=%b we=%b want 0/1/0", count, in_ready, mem_we);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_back_to_back();
    test_j_type();
    test_full();
    test_clr_inflight();
    test_illegal();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
